// File: rtl/dma_burst_master_if.sv
// 68030 bus-master signal bundle for dma_burst_master.
// master: DMA side (BR/OWN/strobes/DATA_O out), slave: bus/arbiter side.
interface dma_burst_master_if #(
  parameter int DATA_W = 32
);
  logic              BR;
  logic              _BG;
  logic              _BGACK_I;
  logic              OWN;
  logic              AS_O_;
  logic              DS_O_;
  logic              RW_O;
  logic [1:0]        _DSACK;
  logic              _STERM;
  logic              _BERR;
  logic [DATA_W-1:0] DATA_I;
  logic [DATA_W-1:0] DATA_O;

  modport master (
    output BR, OWN, AS_O_, DS_O_, RW_O, DATA_O,
    input  _BG, _BGACK_I, _DSACK, _STERM, _BERR, DATA_I
  );

  modport slave (
    input  BR, OWN, AS_O_, DS_O_, RW_O, DATA_O,
    output _BG, _BGACK_I, _DSACK, _STERM, _BERR, DATA_I
  );
endinterface

// File: rtl/dma_burst_master.sv
// Burst DMA bus master: local FIFO, length counter, 68030 arbitration.
// Ports: SCLK/rst; bus (68030 master modport); start/DMADIR/xfer_len/
// burst_len/abort control; p_* peripheral FIFO end; FIFOFULL/FIFOEMPTY,
// remain, DONE_INT, ERR status. RESDMAC_WATCHDOG_EN adds a WAIT timeout.
module dma_burst_master #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 24,
  parameter int MAX_BURST  = 4
) (
  input  logic                       SCLK,
  input  logic                       rst,
  dma_burst_master_if.master         bus,
  input  logic                       start,
  input  logic                       DMADIR,
  input  logic [CNT_W-1:0]           xfer_len,
  input  logic [$clog2(MAX_BURST):0] burst_len,
  input  logic                       abort,
  input  logic                       p_push,
  input  logic [DATA_W-1:0]          p_wdata,
  input  logic                       p_pop,
  output logic [DATA_W-1:0]          p_rdata,
  output logic                       FIFOFULL,
  output logic                       FIFOEMPTY,
  output logic [CNT_W-1:0]           remain,
  output logic                       DONE_INT,
  output logic                       ERR
);
  localparam int BLW = $clog2(MAX_BURST) + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_REQ, S_ASSERT,
    S_WAIT, S_NEXT, S_REL, S_DONE
  } state_t;

  state_t r_st, w_nx;

  logic [CNT_W-1:0]  r_remain;
  logic [BLW-1:0]    r_bcnt;
  logic [BLW-1:0]    r_blen;
  logic              r_dir;
  logic              r_done;
  logic              r_err;
  logic              r_abt;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [LW-1:0]     r_lvl;

  logic [BLW-1:0]    w_bl_in;
  logic [CNT_W-1:0]  w_blen;
  logic [CNT_W-1:0]  w_b;
  logic [CNT_W-1:0]  w_lvl;
  logic [CNT_W-1:0]  w_free;
  logic              w_elig;
  logic              w_term;
  logic              w_fire;
  logic              w_fail;
  logic              w_wd_to;
  logic              w_go;
  logic              w_abt;
  logic              w_own;
  logic              w_strb;
  logic              w_push;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [DATA_W-1:0] w_wdat;

  // 0 behaves as 1; oversize requests clamp to MAX_BURST
  always_comb begin
    w_bl_in = burst_len;
    if (burst_len == '0)
      w_bl_in = BLW'(1);
    else if (burst_len > BLW'(MAX_BURST))
      w_bl_in = BLW'(MAX_BURST);
  end

  assign w_blen = CNT_W'(r_blen);
  assign w_b    = (r_remain < w_blen) ? r_remain : w_blen;
  assign w_lvl  = CNT_W'(r_lvl);
  assign w_free = CNT_W'(FIFO_DEPTH) - w_lvl;
  assign w_elig = r_dir ? (w_lvl >= w_b) : (w_free >= w_b);

  // 16-bit-only ack (01) is deliberately not a termination
  assign w_term = !bus._STERM || (bus._DSACK == 2'b00);
  assign w_fire = (r_st == S_WAIT) && bus._BERR && w_term;
  assign w_fail = (r_st == S_WAIT) && (!bus._BERR || w_wd_to);
  assign w_go   = (r_st == S_IDLE) && start;
  // a short abort pulse is remembered until the next cycle boundary
  assign w_abt  = abort || r_abt;

`ifdef RESDMAC_WATCHDOG_EN
  logic [7:0] r_wd;
  always_ff @(posedge SCLK or posedge rst) begin
    if (rst)
      r_wd <= '0;
    else
      r_wd <= (r_st == S_WAIT) ? r_wd + 8'd1 : 8'd0;
  end
  assign w_wd_to = (r_st == S_WAIT) && (r_wd == 8'hFF) && !w_term;
`else
  assign w_wd_to = 1'b0;
`endif

  always_comb begin
    w_nx = r_st;
    unique case (r_st)
      S_IDLE:
        if (start)
          w_nx = (xfer_len == '0) ? S_DONE : S_ARB;
      S_ARB:
        if (w_abt)
          w_nx = S_DONE;
        else if (w_elig)
          w_nx = S_REQ;
      S_REQ:
        if (!bus._BG && bus._BGACK_I)
          w_nx = S_ASSERT;
      S_ASSERT:
        w_nx = S_WAIT;
      S_WAIT:
        if (w_fail)
          w_nx = S_REL;
        else if (w_term)
          w_nx = S_NEXT;
      S_NEXT:
        if (r_bcnt == '0 || r_remain == '0 || w_abt)
          w_nx = S_REL;
        else
          w_nx = S_ASSERT;
      S_REL:
        if (r_remain == '0 || r_err || w_abt)
          w_nx = S_DONE;
        else
          w_nx = S_ARB;
      S_DONE:
        w_nx = S_IDLE;
      default:
        w_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      r_st     <= S_IDLE;
      r_remain <= '0;
      r_bcnt   <= '0;
      r_blen   <= BLW'(1);
      r_dir    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_abt    <= 1'b0;
    end else begin
      r_st  <= w_nx;
      r_abt <= (r_st == S_IDLE) ? 1'b0 : (r_abt | abort);
      if (w_go) begin
        r_remain <= xfer_len;
        r_dir    <= DMADIR;
        r_blen   <= w_bl_in;
        r_done   <= 1'b0;
        r_err    <= 1'b0;
      end
      if (r_st == S_DONE)
        r_done <= 1'b1;
      if (w_fail)
        r_err <= 1'b1;
      if (r_st == S_ARB && w_nx == S_REQ)
        r_bcnt <= w_b[BLW-1:0];
      if (w_fire) begin
        r_remain <= r_remain - 1'b1;
        r_bcnt   <= r_bcnt - 1'b1;
      end
    end
  end

  // bus side is the far end of the FIFO from the peripheral
  assign w_push    = (w_fire && !r_dir) || p_push;
  assign w_pop     = (w_fire && r_dir) || p_pop;
  assign w_wdat    = (w_fire && !r_dir) ? bus.DATA_I : p_wdata;
  assign w_push_ok = w_push && (r_lvl != LW'(FIFO_DEPTH));
  assign w_pop_ok  = w_pop && (r_lvl != '0);

  always_ff @(posedge SCLK) begin
    if (w_push_ok)
      r_mem[r_wp] <= w_wdat;
  end

  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push_ok)
        r_wp <= r_wp + 1'b1;
      if (w_pop_ok)
        r_rp <= r_rp + 1'b1;
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_lvl <= r_lvl + 1'b1;
        2'b01:   r_lvl <= r_lvl - 1'b1;
        default: r_lvl <= r_lvl;
      endcase
    end
  end

  // bus outputs decode straight from state so reset drops them at once
  assign w_own  = (r_st == S_ASSERT) || (r_st == S_WAIT) ||
                  (r_st == S_NEXT);
  assign w_strb = (r_st == S_ASSERT) || (r_st == S_WAIT);

  assign bus.BR     = (r_st == S_REQ);
  assign bus.OWN    = w_own;
  assign bus.AS_O_  = !w_strb;
  assign bus.DS_O_  = !w_strb;
  assign bus.RW_O   = w_own ? !r_dir : 1'b1;
  assign bus.DATA_O = (w_own && r_dir) ? r_mem[r_rp] : '0;

  assign p_rdata   = r_mem[r_rp];
  assign FIFOFULL  = (r_lvl == LW'(FIFO_DEPTH));
  assign FIFOEMPTY = (r_lvl == '0);
  assign remain    = r_remain;
  assign DONE_INT  = r_done;
  assign ERR       = r_err;
endmodule

// File: tb/tb_dma_burst_master.sv
// Directed bench for dma_burst_master with a simple 68030 slave model.
// Build with +define+RESDMAC_WATCHDOG_EN to exercise the WAIT timeout.
module tb_dma_burst_master;
  localparam int DW = 32;
  localparam int CW = 24;

  logic SCLK = 1'b0;
  logic rst  = 1'b1;
  always #5 SCLK = ~SCLK;

  dma_burst_master_if #(.DATA_W(DW)) bus ();

  logic          start = 1'b0;
  logic          DMADIR = 1'b0;
  logic [CW-1:0] xfer_len = '0;
  logic [2:0]    burst_len = '0;
  logic          abort = 1'b0;
  logic          p_push = 1'b0;
  logic [DW-1:0] p_wdata = '0;
  logic          p_pop = 1'b0;
  logic [DW-1:0] p_rdata;
  logic          FIFOFULL, FIFOEMPTY, DONE_INT, ERR;
  logic [CW-1:0] remain;

  dma_burst_master #(
    .DATA_W(DW), .FIFO_DEPTH(8), .CNT_W(CW), .MAX_BURST(4)
  ) dut (
    .SCLK(SCLK), .rst(rst), .bus(bus),
    .start(start), .DMADIR(DMADIR), .xfer_len(xfer_len),
    .burst_len(burst_len), .abort(abort),
    .p_push(p_push), .p_wdata(p_wdata),
    .p_pop(p_pop), .p_rdata(p_rdata),
    .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY),
    .remain(remain), .DONE_INT(DONE_INT), .ERR(ERR)
  );

  int checks = 0;
  int errors = 0;

  // slave model: 0 = never ack, 1 = zero-wait _STERM, 2 = _DSACK=00
  int          ack_mode = 0;
  logic [31:0] berr_cyc = '0;
  logic [31:0] as_cnt = '0;
  int          br_rises = 0;
  int          ten_cnt = 0;
  logic        p_br = 1'b0, p_as = 1'b1, p_own = 1'b0;
  int          ten_q[$];
  logic [DW-1:0] wlog[$];

  assign bus._BG      = ~bus.BR;
  assign bus._BGACK_I = 1'b1;
  assign bus._STERM   = !(ack_mode == 1 && !bus.AS_O_);
  assign bus._DSACK   = (ack_mode == 2 && !bus.AS_O_) ? 2'b00 : 2'b11;
  assign bus._BERR    = !(berr_cyc != 0 && as_cnt == berr_cyc &&
                          !bus.AS_O_);
  assign bus.DATA_I   = 32'hA000_0000 + as_cnt;

  // bus activity monitor: counts BR requests, strobe cycles, tenures
  always @(posedge SCLK) begin
    #1;
    if (rst) begin
      ten_cnt = 0;
    end else begin
      if (bus.BR && !p_br)
        br_rises = br_rises + 1;
      if (!bus.AS_O_ && p_as) begin
        as_cnt  = as_cnt + 1;
        ten_cnt = ten_cnt + 1;
        wlog.push_back(bus.DATA_O);
      end
      if (!bus.OWN && p_own) begin
        ten_q.push_back(ten_cnt);
        ten_cnt = 0;
      end
    end
    p_br  = bus.BR;
    p_as  = bus.AS_O_;
    p_own = bus.OWN;
  end

  task automatic tick();
    @(posedge SCLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (DONE_INT !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, DONE_INT, 1);
  endtask

  task automatic kick(input logic dir, input int len, input int bl);
    DMADIR    = dir;
    xfer_len  = CW'(len);
    burst_len = 3'(bl);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_br"},  bus.BR, 0);
    chk({tag, "_own"}, bus.OWN, 0);
    chk({tag, "_as"},  bus.AS_O_, 1);
    chk({tag, "_ds"},  bus.DS_O_, 1);
    chk({tag, "_rw"},  bus.RW_O, 1);
    chk({tag, "_do"},  bus.DATA_O, 0);
    chk({tag, "_emp"}, FIFOEMPTY, 1);
    chk({tag, "_ful"}, FIFOFULL, 0);
    chk({tag, "_rem"}, remain, 0);
    chk({tag, "_dn"},  DONE_INT, 0);
    chk({tag, "_err"}, ERR, 0);
  endtask

  initial begin
    int br0;
    logic [31:0] a0;
    int n;

    repeat (3) tick();
    chk_reset("rst0");
    rst = 1'b0;
    tick();

    // T1: write 8 words in two bursts of 4; 9th push is dropped
    for (int i = 0; i < 9; i++) begin
      p_push  = 1'b1;
      p_wdata = 32'h1111_0000 + 32'(i);
      tick();
    end
    p_push = 1'b0;
    chk("t1_full", FIFOFULL, 1);
    br0 = br_rises;
    ten_q.delete();
    wlog.delete();
    ack_mode = 1;
    kick(1'b1, 8, 4);
    wait_done("t1_done");
    chk("t1_rem", remain, 0);
    chk("t1_emp", FIFOEMPTY, 1);
    chk("t1_err", ERR, 0);
    chk("t1_brs", br_rises - br0, 2);
    chk("t1_nten", ten_q.size(), 2);
    chk("t1_ten0", ten_q[0], 4);
    chk("t1_ten1", ten_q[1], 4);
    chk("t1_nw", wlog.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t1_w%0d", i), wlog[i], 32'h1111_0000 + 32'(i));

    // T2: read 6 words via _DSACK=00, bursts of 4 then 2
    ack_mode = 2;
    a0 = as_cnt;
    ten_q.delete();
    kick(1'b0, 6, 4);
    wait_done("t2_done");
    chk("t2_rem", remain, 0);
    chk("t2_ten0", ten_q[0], 4);
    chk("t2_ten1", ten_q[1], 2);
    chk("t2_ful", FIFOFULL, 0);
    chk("t2_emp", FIFOEMPTY, 0);
    for (int i = 0; i < 6; i++) begin
      p_pop = 1'b1;
      chk($sformatf("t2_r%0d", i), p_rdata,
          32'hA000_0000 + a0 + 32'(i + 1));
      tick();
    end
    chk("t2_emp6", FIFOEMPTY, 1);
    tick();
    chk("t2_underflow", FIFOEMPTY, 1);
    p_pop = 1'b0;

    // T3: _BERR on 3rd cycle; burst_len 7 clamps to 4
    ack_mode = 1;
    berr_cyc = as_cnt + 3;
    ten_q.delete();
    kick(1'b0, 10, 7);
    wait_done("t3_done");
    chk("t3_err", ERR, 1);
    chk("t3_rem", remain, 8);
    chk("t3_ten0", ten_q[0], 3);
    chk("t3_own", bus.OWN, 0);
    berr_cyc = '0;
    p_pop = 1'b1;
    repeat (2) tick();
    p_pop = 1'b0;
    chk("t3_emp", FIFOEMPTY, 1);

    // T4: zero-length transfer
    br0 = br_rises;
    kick(1'b0, 0, 4);
    chk("t4_dn0", DONE_INT, 0);
    chk("t4_errclr", ERR, 0);
    tick();
    chk("t4_dn", DONE_INT, 1);
    chk("t4_nobr", br_rises - br0, 0);

    // T5: abort pulse during WAIT of cycle 2
    ten_q.delete();
    a0 = as_cnt;
    kick(1'b0, 8, 4);
    n = 0;
    while (as_cnt != a0 + 2 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_reach", as_cnt - a0, 2);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("t5_done");
    chk("t5_rem", remain, 6);
    chk("t5_ten0", ten_q[0], 2);
    chk("t5_err", ERR, 0);

    // T6: reset while owning the bus (write, FIFO holds 2 words)
    chk("t6_pre_emp", FIFOEMPTY, 0);
    kick(1'b1, 8, 2);
    n = 0;
    while (bus.OWN !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("t6_own", bus.OWN, 1);
    chk("t6_rw", bus.RW_O, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("t6");
    tick();
    rst = 1'b0;
    tick();

    // T7: no termination at all
    ack_mode = 0;
    kick(1'b0, 1, 1);
    n = 0;
    while (bus.AS_O_ !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    chk("t7_as", bus.AS_O_, 0);
`ifdef RESDMAC_WATCHDOG_EN
    repeat (256) tick();
    chk("t7_wd_early", ERR, 0);
    chk("t7_wd_as", bus.AS_O_, 0);
    tick();
    chk("t7_wd_err", ERR, 1);
    chk("t7_wd_own", bus.OWN, 0);
    wait_done("t7_wd_done");
`else
    repeat (1000) tick();
    chk("t7_hold_as", bus.AS_O_, 0);
    chk("t7_hold_own", bus.OWN, 1);
    chk("t7_hold_err", ERR, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_burst_master.md
Name: dma_burst_master

Overview:
- Parametrised successor to the single-longword SDMAC bus-master datapath.
- Owns a local FIFO and a programmable transfer-length counter.
- Arbitrates for the 68030 bus (BR/_BG/_BGACK) and runs multi-longword bursts per bus tenure in either direction.
- Terminates bus cycles on _STERM or 32-bit _DSACK, and aborts cleanly on _BERR or a software abort.

Parameters:
DATA_W, 32, CPU-side and FIFO data width in bits
FIFO_DEPTH, 8, FIFO entries; power of two, 2..64
CNT_W, 24, transfer-length counter width, in longwords
MAX_BURST, 4, maximum cycles per bus tenure; 1..FIFO_DEPTH

Ports:
SCLK  in  1  system clock (CPUCLKB); all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; latches xfer_len, burst_len, DMADIR; ignored unless IDLE
DMADIR  in  1  1 = FIFO to memory (bus write), 0 = memory to FIFO (bus read)
xfer_len  in  CNT_W  longwords to move; 0 completes immediately
burst_len  in  clog2(MAX_BURST)+1  requested burst; 0 is treated as 1; values >MAX_BURST are clamped
abort  in  1  software stop; honoured at the next cycle boundary
BR  out  1  bus request
_BG  in  1  bus grant, active low
_BGACK_I  in  1  external bus-grant-acknowledge sense
OWN  out  1  we are bus master (drives _BGACK low and the level-shifter direction)
AS_O_  out  1  address strobe
DS_O_  out  1  data strobe
RW_O  out  1  ~DMADIR while OWN
_DSACK  in  2  dynamic-size acknowledge
_STERM  in  1  synchronous termination
_BERR  in  1  bus error
DATA_I  in  DATA_W  CPU data in (bus read)
DATA_O  out  DATA_W  CPU data out (bus write), from FIFO head
p_push  in  1  peripheral writes p_wdata into FIFO
p_wdata  in  DATA_W  peripheral data
p_pop  in  1  peripheral reads FIFO head
p_rdata  out  DATA_W  FIFO head
FIFOFULL  out  1  level == FIFO_DEPTH
FIFOEMPTY  out  1  level == 0
remain  out  CNT_W  longwords still to transfer
DONE_INT  out  1  sticky; set on completion; cleared by start
ERR  out  1  sticky; set on _BERR or watchdog; cleared by start

Behaviour:
- Reset values: BR=0, OWN=0, AS_O_=1, DS_O_=1, RW_O=1, DATA_O=0, FIFO empty (FIFOEMPTY=1, FIFOFULL=0), remain=0, DONE_INT=0, ERR=0, state IDLE.
- Reset mid-operation releases the bus within the same asynchronous event. The FIFO contents are discarded.
- FIFO:
  - Synchronous, with level counter 0..FIFO_DEPTH and wrapping read/write pointers.
  - A push when full is dropped; a pop when empty returns the stale head and does not change the level.
  - Simultaneous push and pop at the same cycle leaves the level unchanged.
  - The bus side uses the same FIFO, as the opposite end from the peripheral.
- Burst size: B = min(burst_len, remain).
- Burst eligibility:
  - DMADIR=1 requires level >= B.
  - DMADIR=0 requires FIFO_DEPTH - level >= B.
- State machine:
  - IDLE: on start, latch inputs, set remain=xfer_len, clear DONE_INT and ERR. If xfer_len=0, go to DONE. Otherwise go to ARB.
  - ARB: wait until the burst is eligible, then BR=1 and go to REQ. If abort, go to DONE.
  - REQ: wait for _BG=0, _BGACK_I=1 and external AS released. Then BR=0, OWN=1, and go to ASSERT next cycle.
  - ASSERT: AS_O_=0 and DS_O_=0. For a write, DATA_O is presented from the FIFO head. Go to WAIT.
  - WAIT:
    - _BERR=0 has priority: ERR=1, go to RELEASE.
    - Termination (_STERM=0 or _DSACK=2'b00):
      - Bus read: push DATA_I into the FIFO.
      - Bus write: pop the FIFO.
      - Decrement remain and the burst count, negate the strobes, go to NEXT.
    - A 16-bit-only ack (_DSACK=2'b01) is not termination; WAIT continues.
  - NEXT: strobes negated for one cycle. Go to RELEASE if any of: burst count is 0, remain is 0, or abort. Otherwise go to ASSERT.
  - RELEASE: OWN=0, RW_O=1. If remain==0, ERR, or abort, go to DONE; otherwise go to ARB.
  - DONE: DONE_INT=1, go to IDLE.
- Latency and ordering:
  - Minimum cycle is 3 SCLK (ASSERT, WAIT, NEXT) with zero-wait termination.
  - abort never truncates an active strobe cycle.
  - A peripheral push/pop in the same cycle as a bus-side pop/push is legal; the level is net-updated.

Optional Feature:
- Macro: RESDMAC_WATCHDOG_EN.
- When defined: an 8-bit counter runs in WAIT. If it reaches 255 with no termination, the block behaves as for _BERR (ERR=1, RELEASE).
- When undefined: WAIT is unbounded and the counter is not synthesised.

Test Plan:
- DMADIR=1, xfer_len=8, burst_len=4, 8 words pushed, zero-wait _STERM → two tenures of 4 cycles each, BR deasserted between tenures, remain reaches 0, DONE_INT=1, FIFO empty.
- DMADIR=0, xfer_len=6, burst_len=4, FIFO_DEPTH=8, peripheral never pops → bursts of 4 then 2; FIFOFULL=0 with level 6; DATA_I values appear in order on p_rdata.
- _BERR=0 on the 3rd cycle of a 4-burst → ERR=1, OWN=0 the cycle after RELEASE, remain=xfer_len-2, DONE_INT=1.
- xfer_len=0 with start → DONE_INT=1 within 2 cycles, BR never asserted.
- abort asserted during WAIT of cycle 2 → that cycle completes, bus released after NEXT, remain=xfer_len-2; rst asserted while OWN=1 → all outputs return to reset values immediately.
- With RESDMAC_WATCHDOG_EN: hold _DSACK=2'b11 and _STERM=1 → ERR=1 after 256 WAIT cycles; without the macro, the block is still in WAIT after 1000 cycles.
